// File: rtl/obi_mailbox_slave.sv
// OBI mailbox slave: a single-outstanding OBI target exposing a TX FIFO
// (bus writes in, ready/valid stream out), an RX FIFO (stream in, bus reads
// out), a status word, a pulse-style control register and a scratch word.
// Every bus side effect is applied in the grant cycle; the response follows
// one cycle later.
module obi_mailbox_slave #(
  parameter int WordSize = 32,
  parameter int AddrSize = 32,
  parameter int Depth    = 8
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_aresetn,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [AddrSize-1:0] addr_i,
  input  logic [WordSize-1:0] wdata_i,
  output logic                rvalid_o,
  output logic [WordSize-1:0] rdata_o,
  output logic                tx_valid_o,
  output logic [WordSize-1:0] tx_data_o,
  input  logic                tx_ready_i,
  input  logic                rx_valid_i,
  input  logic [WordSize-1:0] rx_data_i,
  output logic                rx_ready_o
);

  localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW     = $clog2(Depth) + 1;
  localparam int NumBytes = ((WordSize / 8) < 4) ? (WordSize / 8) : 4;

  localparam logic [1:0] RegData    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegCtrl    = 2'd2;
  localparam logic [1:0] RegScratch = 2'd3;

  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // Pack the status word from the pre-cycle FIFO state and sticky flags.
  function automatic logic [WordSize-1:0] pack_status(
    input logic [CntW-1:0] txc,
    input logic [CntW-1:0] rxc,
    input logic            txf,
    input logic            txe,
    input logic            rxf,
    input logic            rxe,
    input logic            ovf,
    input logic            udf
  );
    logic [31:0] s;
    s        = '0;
    s[0]     = txf;
    s[1]     = txe;
    s[2]     = rxf;
    s[3]     = rxe;
    s[4]     = ovf;
    s[5]     = udf;
    s[15:8]  = 8'(txc);
    s[23:16] = 8'(rxc);
    return WordSize'(s);
  endfunction

  // Merge new write data into an existing word under per-byte enables.
  function automatic logic [WordSize-1:0] merge_bytes(
    input logic [WordSize-1:0] old_word,
    input logic [WordSize-1:0] new_word,
    input logic [3:0]          strobes
  );
    logic [WordSize-1:0] m;
    m = old_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (strobes[i]) m[8*i +: 8] = new_word[8*i +: 8];
    end
    return m;
  endfunction

  // Response stage (p1): pending doubles as the response-valid flag.
  logic                rsp_vld_p1;
  logic [WordSize-1:0] rsp_data_p1;

  // FIFO state
  logic [WordSize-1:0] tx_mem [Depth];
  logic [WordSize-1:0] rx_mem [Depth];
  logic [PtrW-1:0]     tx_wr_ptr, tx_rd_ptr;
  logic [PtrW-1:0]     rx_wr_ptr, rx_rd_ptr;
  logic [CntW-1:0]     tx_count, rx_count;
  logic                tx_full, tx_empty, rx_full, rx_empty;

  // Sticky flags and scratch
  logic                tx_ovf, rx_udf;
  logic [WordSize-1:0] scratch;

  // Decoded events for the current cycle
  logic [1:0]          reg_sel;
  logic                tx_push_req, tx_push, tx_pop;
  logic                rx_pop_req, rx_pop, rx_push;
  logic                ctrl_wr, clr_flags, flush, scratch_wr;
  logic [WordSize-1:0] rsp_data_p0;

  // Only addr_i[3:2] selects a register; the remaining bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr_i[AddrSize-1:4], addr_i[1:0]};

  assign reg_sel  = addr_i[3:2];
  assign gnt_o    = req_i & ~rsp_vld_p1;

  assign tx_full  = (tx_count == CntFull);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CntFull);
  assign rx_empty = (rx_count == '0);

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_mem[tx_rd_ptr];
  assign rx_ready_o = ~rx_full;
  assign rvalid_o   = rsp_vld_p1;
  assign rdata_o    = rsp_data_p1;

  // Decode granted requests and stream handshakes into per-cycle events.
  always_comb begin
    tx_push_req = gnt_o & we_i & (reg_sel == RegData);
    rx_pop_req  = gnt_o & ~we_i & (reg_sel == RegData);
    ctrl_wr     = gnt_o & we_i & (reg_sel == RegCtrl);
    scratch_wr  = gnt_o & we_i & (reg_sel == RegScratch);
    clr_flags   = ctrl_wr & wdata_i[0];
    flush       = ctrl_wr & wdata_i[1];
    tx_push     = tx_push_req & ~tx_full;
    rx_pop      = rx_pop_req & ~rx_empty;
    tx_pop      = tx_valid_o & tx_ready_i;
    rx_push     = rx_valid_i & rx_ready_o;
  end

  // Read-data mux; writes and CTRL reads answer with zero.
  always_comb begin
    rsp_data_p0 = '0;
    if (!we_i) begin
      case (reg_sel)
        RegData:    rsp_data_p0 = rx_empty ? '0 : rx_mem[rx_rd_ptr];
        RegStatus:  rsp_data_p0 = pack_status(tx_count, rx_count, tx_full, tx_empty,
                                              rx_full, rx_empty, tx_ovf, rx_udf);
        RegCtrl:    rsp_data_p0 = '0;
        RegScratch: rsp_data_p0 = scratch;
        default:    rsp_data_p0 = '0;
      endcase
    end
  end

  // ---- p0 -> p1: grant cycle captures the response, issued next cycle ----
  // Response register: valid for exactly one cycle after each grant.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else begin
      rsp_vld_p1 <= gnt_o;
      if (gnt_o) rsp_data_p1 <= rsp_data_p0;
    end
  end

  // TX FIFO: bus pushes, stream pops; flush overrides a concurrent pop.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      for (int i = 0; i < Depth; i++) tx_mem[i] <= '0;
    end else if (flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= wdata_i;
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CntOne;
      else if (tx_pop && !tx_push) tx_count <= tx_count - CntOne;
    end
  end

  // RX FIFO: stream pushes, bus pops; flush discards a concurrent push.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      for (int i = 0; i < Depth; i++) rx_mem[i] <= '0;
    end else if (flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= rx_data_i;
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CntOne;
      else if (rx_pop && !rx_push) rx_count <= rx_count - CntOne;
    end
  end

  // Sticky error flags: set by dropped writes / empty reads, cleared by CTRL bit0.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else if (clr_flags) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_push_req && tx_full)  tx_ovf <= 1'b1;
      if (rx_pop_req && rx_empty)  rx_udf <= 1'b1;
    end
  end

  // Scratch register with byte-lane writes.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      scratch <= '0;
    end else if (scratch_wr) begin
      scratch <= merge_bytes(scratch, wdata_i, be_i);
    end
  end

endmodule

// File: tb/tb_obi_mailbox_slave.sv
// Testbench for obi_mailbox_slave: bus responses are checked through a
// read-data scoreboard, TX stream output through a TX word scoreboard.
module tb_obi_mailbox_slave;

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_STAT = 2'd1;
  localparam logic [1:0] R_CTRL = 2'd2;
  localparam logic [1:0] R_SCR  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, tx_valid, rx_ready;
  logic [31:0] rdata, tx_data;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] rx_data = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_q[$];
  logic [31:0] tx_q[$];

  always #5 clk = ~clk;

  obi_mailbox_slave #(.WordSize(32), .AddrSize(32), .Depth(8)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready)
  );

  // Expected STATUS word for an 8-deep mailbox.
  function automatic logic [31:0] st(input int txc, input int rxc, input bit ovf, input bit udf);
    logic [31:0] s;
    s = '0;
    s[0] = (txc == 8);
    s[1] = (txc == 0);
    s[2] = (rxc == 8);
    s[3] = (rxc == 0);
    s[4] = ovf;
    s[5] = udf;
    s[15:8]  = txc[7:0];
    s[23:16] = rxc[7:0];
    return s;
  endfunction

  // One OBI transaction. side=1 pushes sword on RX, side=2 pops TX, both in the grant cycle.
  task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] wd,
                     input logic [3:0] b, input logic [31:0] exp, input int side,
                     input logic [31:0] sword);
    int n;
    logic [31:0] e;
    @(negedge clk);
    req = 1'b1; we = w; be = b; wdata = wd;
    addr = ($urandom() & 32'hFFFF_FFF3) | {28'h0, r, 2'b00};
    #1;
    n = 0;
    while (gnt !== 1'b1 && n < 16) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL gnt_timeout: gnt=%b want 1", gnt);
      req = 1'b0;
      return;
    end
    if (side == 1) begin rx_valid = 1'b1; rx_data = sword; end
    if (side == 2) begin
      tx_ready = 1'b1;
      if (tx_q.size() > 0) begin
        e = tx_q.pop_front();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== e) begin
          errors++;
          $display("FAIL side_tx_pop: valid=%b data=%h want 1/%h", tx_valid, tx_data, e);
        end
      end
    end
    rd_q.push_back(exp);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    e = rd_q.pop_front();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rvalid_pulse: rvalid=%b want 1", rvalid);
    end else begin
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL rdata reg%0d: got %h want %h", r, rdata, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_one_cycle: rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic rx_push(input logic [31:0] word);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = word;
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_ready_push: got %b want 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic tx_drain(input int cnt);
    logic [31:0] e;
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      #1;
      e = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hXXXX_XXXX;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        errors++;
        $display("FAIL tx_stream[%0d]: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, e);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_drained: tx_valid=%b want 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 32'h0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: rvalid=%b rdata=%h tx_valid=%b tx_data=%h rx_ready=%b want 0/0/0/0/1",
               rvalid, rdata, tx_valid, tx_data, rx_ready);
    end
    rst_n = 1'b1;
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
  endtask

  task automatic test_tx_fifo;
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      bus(1, R_DATA, words[i], 4'hF, 32'h0, 0, 0);
      tx_q.push_back(words[i]);
    end
    bus(0, R_STAT, 0, 4'h0, st(3, 0, 0, 0), 0, 0);
    tx_drain(3);
  endtask

  task automatic test_tx_overflow;
    for (int i = 0; i < 9; i++) begin
      bus(1, R_DATA, 32'h100 + i, 4'hF, 32'h0, 0, 0);
      if (i < 8) tx_q.push_back(32'h100 + i);
    end
    bus(0, R_STAT, 0, 4'h0, 32'h0000_0819, 0, 0);
    bus(1, R_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, st(8, 0, 0, 0), 0, 0);
    // Write while full, stream pop in the same cycle: still dropped.
    bus(1, R_DATA, 32'h999, 4'hF, 32'h0, 2, 0);
    bus(0, R_STAT, 0, 4'h0, st(7, 0, 1, 0), 0, 0);
    tx_drain(7);
    bus(1, R_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
  endtask

  task automatic test_rx_fifo;
    rx_push(32'hA5A5_0001);
    bus(0, R_DATA, 0, 4'h0, 32'hA5A5_0001, 0, 0);
    bus(0, R_DATA, 0, 4'h0, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, 32'h0000_002A, 0, 0);
    // Empty read with a simultaneous stream push: returns 0, word kept.
    bus(0, R_DATA, 0, 4'h0, 32'h0, 1, 32'h5555_AAAA);
    bus(0, R_STAT, 0, 4'h0, st(0, 1, 0, 1), 0, 0);
    bus(0, R_DATA, 0, 4'h0, 32'h5555_AAAA, 0, 0);
    bus(1, R_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);
    // Pop and push in the same cycle: count unchanged.
    rx_push(32'h0000_0001);
    bus(0, R_DATA, 0, 4'h0, 32'h0000_0001, 1, 32'h0000_0002);
    bus(0, R_STAT, 0, 4'h0, st(0, 1, 0, 0), 0, 0);
    bus(0, R_DATA, 0, 4'h0, 32'h0000_0002, 0, 0);
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
  endtask

  task automatic test_scratch;
    bus(1, R_SCR, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0);
    bus(1, R_SCR, 32'h0000_0000, 4'b0010, 32'h0, 0, 0);
    bus(0, R_SCR, 0, 4'h0, 32'hDEAD_00EF, 0, 0);
    bus(1, R_STAT, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
    bus(0, R_CTRL, 0, 4'h0, 32'h0, 0, 0);
  endtask

  task automatic test_flush;
    for (int i = 0; i < 8; i++) begin
      bus(1, R_DATA, 32'h300 + i, 4'hF, 32'h0, 0, 0);
      tx_q.push_back(32'h300 + i);
    end
    for (int i = 0; i < 8; i++) rx_push(32'h200 + i);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_ready_full: got %b want 0", rx_ready);
    end
    bus(0, R_STAT, 0, 4'h0, 32'h0008_0805, 0, 0);
    bus(0, R_DATA, 0, 4'h0, 32'h200, 0, 0);
    // Flush with a stream push in the same cycle: push discarded.
    bus(1, R_CTRL, 32'h2, 4'hF, 32'h0, 1, 32'h0000_0BAD);
    tx_q.delete();
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_stream: tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
    end
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
    bus(0, R_DATA, 0, 4'h0, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, st(0, 0, 0, 1), 0, 0);
    // Both CTRL bits: clear flags and flush together.
    bus(1, R_DATA, 32'h77, 4'hF, 32'h0, 0, 0);
    tx_q.push_back(32'h77);
    bus(0, R_STAT, 0, 4'h0, st(1, 0, 0, 1), 0, 0);
    bus(1, R_CTRL, 32'h3, 4'hF, 32'h0, 0, 0);
    tx_q.delete();
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {28'h0, R_SCR, 2'b00};
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_gnt: got %b want 1", gnt);
    end
    rd_q.push_back(32'hDEAD_00EF);
    @(posedge clk); #1;
    addr = {28'h0, R_STAT, 2'b00};
    @(negedge clk);
    checks++;
    if (gnt !== 1'b0 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: gnt=%b rvalid=%b want 0/1", gnt, rvalid);
    end
    e = rd_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL b2b_rdata0: got %h want %h", rdata, e);
    end
    @(posedge clk); #1;
    checks++;
    if (gnt !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_gnt: gnt=%b rvalid=%b want 1/0", gnt, rvalid);
    end
    rd_q.push_back(32'h0000_000A);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    e = rd_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      errors++;
      $display("FAIL b2b_rdata1: rvalid=%b rdata=%h want 1/%h", rvalid, rdata, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bus(1, R_DATA, 32'h1234, 4'hF, 32'h0, 0, 0);
    rx_push(32'h55);
    // Reset during the grant cycle: the response must never appear.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {28'h0, R_SCR, 2'b00};
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt: got %b want 1", gnt);
    end
    rst_n = 1'b0;
    #1;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_rvalid[%0d]: got %b want 0", i, rvalid);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tx_q.delete();
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_state: tx_valid=%b rx_ready=%b rdata=%h want 0/1/0", tx_valid, rx_ready, rdata);
    end
    bus(0, R_SCR, 0, 4'h0, 32'h0, 0, 0);
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
    // Reset while rvalid is high: it must drop without waiting for a clock.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {28'h0, R_STAT, 2'b00};
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_rvalid: got %b want 0", rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, R_STAT, 0, 4'h0, 32'h0000_000A, 0, 0);
  endtask

  initial begin
    test_reset;
    test_tx_fifo;
    test_tx_overflow;
    test_rx_fifo;
    test_scratch;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
